mem_bus_arbiter: RTL and testbench

- Single-port memory arbiter directly downstream of the single-cycle datapath.
- Merges the instruction-cache refill port (IC: req/ready/addr/instr) and the data-memory port (DM: rd/wen/addr/wd/f3/ready/rdata) onto one request/acknowledge memory bus.
- Generates byte enables and lane-replicated write data.
- Returns the raw 32-bit word to whichever requester won, with a one-cycle ready pulse.

---
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - arbitrates IC refill and DM ports onto one req/ack memory bus
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of fixed DM_PRIORITY.
module mem_bus_arbiter #(
  parameter int DM_PRIORITY = 1,
  parameter int XLEN        = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic            o_ic_ready,
  output logic [XLEN-1:0] o_ic_data,
  input  logic            i_dm_rd,
  input  logic            i_dm_wen,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wd,
  input  logic [2:0]      i_dm_f3,
  output logic            o_dm_ready,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS_IC, BUS_DM, RESP} state_t;

  state_t          state, state_n;
  logic            mem_req_n, mem_we_n, ic_ready_n, dm_ready_n;
  logic [XLEN-1:0] mem_addr_n, mem_wdata_n, ic_data_n, dm_rdata_n;
  logic [3:0]      mem_be_n;
  logic            dm_req, grant_dm;
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;

  logic unused_ok;
  assign unused_ok = &{1'b0, i_dm_f3[2], i_ic_addr[1:0]};

  assign dm_req = i_dm_rd | i_dm_wen;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = IC, 1 = DM; on a tie the other port wins
  logic last_grant, last_grant_n;
  logic unused_prio;
  assign unused_prio = (DM_PRIORITY != 0);
  assign grant_dm    = dm_req && (!i_ic_req || !last_grant);

  always_ff @(posedge i_clk) begin
    if (!i_rst) last_grant <= 1'b0;
    else        last_grant <= last_grant_n;
  end

  always_comb begin
    last_grant_n = last_grant;
    if (state == IDLE && (i_ic_req || dm_req)) last_grant_n = grant_dm;
  end
`else
  assign grant_dm = dm_req && (!i_ic_req || (DM_PRIORITY != 0));
`endif

  // Lane placement of write data; f3[2] (unsigned flag) is irrelevant for stores
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = i_dm_wd;
    case (i_dm_f3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << i_dm_addr[1:0];
        wr_data = {4{i_dm_wd[7:0]}};
      end
      2'b01: begin
        wr_be   = i_dm_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{i_dm_wd[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= 4'b0000;
      o_ic_ready  <= 1'b0;
      o_dm_ready  <= 1'b0;
      o_ic_data   <= '0;
      o_dm_rdata  <= '0;
    end else begin
      state       <= state_n;
      o_mem_req   <= mem_req_n;
      o_mem_we    <= mem_we_n;
      o_mem_addr  <= mem_addr_n;
      o_mem_wdata <= mem_wdata_n;
      o_mem_be    <= mem_be_n;
      o_ic_ready  <= ic_ready_n;
      o_dm_ready  <= dm_ready_n;
      o_ic_data   <= ic_data_n;
      o_dm_rdata  <= dm_rdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    mem_req_n   = o_mem_req;
    mem_we_n    = o_mem_we;
    mem_addr_n  = o_mem_addr;
    mem_wdata_n = o_mem_wdata;
    mem_be_n    = o_mem_be;
    ic_ready_n  = 1'b0;
    dm_ready_n  = 1'b0;
    ic_data_n   = o_ic_data;
    dm_rdata_n  = o_dm_rdata;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_n     = BUS_DM;
          mem_req_n   = 1'b1;
          mem_we_n    = i_dm_wen;
          mem_addr_n  = {i_dm_addr[XLEN-1:2], 2'b00};
          mem_be_n    = i_dm_wen ? wr_be : 4'b1111;
          mem_wdata_n = i_dm_wen ? wr_data : '0;
        end else if (i_ic_req) begin
          state_n     = BUS_IC;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = {i_ic_addr[XLEN-1:2], 2'b00};
          mem_be_n    = 4'b1111;
          mem_wdata_n = '0;
        end
      end
      BUS_IC: begin
        if (i_mem_ack) begin
          state_n    = RESP;
          mem_req_n  = 1'b0;
          ic_data_n  = i_mem_rdata;
          ic_ready_n = 1'b1;
        end
      end
      BUS_DM: begin
        if (i_mem_ack) begin
          state_n    = RESP;
          mem_req_n  = 1'b0;
          dm_rdata_n = i_mem_rdata;
          dm_ready_n = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized bench for mem_bus_arbiter against a transaction-level memory model
module tb_mem_bus_arbiter;
  localparam int DM_PRIO = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_data;
  logic        dm_rd, dm_wen;
  logic [31:0] dm_addr, dm_wd;
  logic [2:0]  dm_f3;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem [0:255];
  bit          last_dm;

  mem_bus_arbiter #(.DM_PRIORITY(DM_PRIO), .XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr), .o_ic_ready(ic_ready), .o_ic_data(ic_data),
    .i_dm_rd(dm_rd), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wd(dm_wd), .i_dm_f3(dm_f3),
    .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_be(mem_be), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] f3, input logic we);
    int n, base;
    logic [3:0] be;
    if (!we) return 4'hF;
    n    = size_bytes(f3);
    base = (int'(a[1:0]) / n) * n;
    be   = 4'h0;
    for (int i = 0; i < n; i++) be[base + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] f3);
    int n;
    logic [31:0] v, r;
    n = size_bytes(f3);
    v = (n == 4) ? wd : (wd & ((32'h1 << (8 * n)) - 32'h1));
    r = 32'h0;
    for (int i = 0; i < 4; i += n) r = r | (v << (8 * i));
    return r;
  endfunction

  function automatic bit pick_dm(input bit ic, input bit dm);
    if (!dm) return 1'b0;
    if (!ic) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_dm;
`else
    return DM_PRIO != 0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b0; ic_req = 1'b0; ic_addr = '0; dm_rd = 1'b0; dm_wen = 1'b0;
    dm_addr = '0; dm_wd = '0; dm_f3 = 3'b010; mem_ack = 1'b0; mem_rdata = '0;
    last_dm = 1'b0;
    tick(); tick();
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_be", {28'b0, mem_be}, 32'h0);
    check("rst_ready", {30'b0, ic_ready, dm_ready}, 32'h0);
    check("rst_icdata", ic_data, 32'h0);
    check("rst_dmrdata", dm_rdata, 32'h0);
    rst = 1'b1;
    tick();
  endtask

  // Runs one bus transaction for whichever requester the model says wins.
  // Entered at a negedge with the FSM about to sample requests in IDLE.
  task automatic serve(input int delay, input bit drop_mid);
    bit          wdm;
    logic [31:0] ea, ewd, rv;
    logic        ewe;
    logic [3:0]  ebe;
    int          idx;
    wdm = pick_dm(ic_req, dm_rd | dm_wen);
    last_dm = wdm;
    if (wdm) begin
      ea  = {dm_addr[31:2], 2'b00};
      ewe = dm_wen;
      ebe = exp_be(dm_addr, dm_f3, dm_wen);
      ewd = exp_wdata(dm_wd, dm_f3);
    end else begin
      ea  = {ic_addr[31:2], 2'b00};
      ewe = 1'b0;
      ebe = 4'hF;
      ewd = '0;
    end
    idx = int'(ea[9:2]);
    rv  = mem[idx];
    tick();
    check("req_rise", {31'b0, mem_req}, 32'h1);
    check("bus_addr", mem_addr, ea);
    check("bus_we", {31'b0, mem_we}, {31'b0, ewe});
    check("bus_be", {28'b0, mem_be}, {28'b0, ebe});
    if (ewe) check("bus_wdata", mem_wdata, ewd);
    for (int d = 0; d < delay; d++) begin
      if (drop_mid && d == 0) begin
        if (wdm) begin dm_rd = 1'b0; dm_wen = 1'b0; end
        else ic_req = 1'b0;
      end
      tick();
      check("hold_req", {31'b0, mem_req}, 32'h1);
      check("hold_addr", mem_addr, ea);
      check("hold_be", {28'b0, mem_be}, {28'b0, ebe});
      check("hold_we", {31'b0, mem_we}, {31'b0, ewe});
      if (ewe) check("hold_wdata", mem_wdata, ewd);
      check("hold_noready", {30'b0, ic_ready, dm_ready}, 32'h0);
    end
    mem_ack = 1'b1;
    mem_rdata = rv;
    tick();
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    check("ready_pair", {30'b0, ic_ready, dm_ready}, wdm ? 32'h1 : 32'h2);
    check("resp_data", wdm ? dm_rdata : ic_data, rv);
    check("req_drop", {31'b0, mem_req}, 32'h0);
    if (ewe)
      for (int b = 0; b < 4; b++)
        if (ebe[b]) mem[idx][8*b +: 8] = ewd[8*b +: 8];
    if (wdm) begin dm_rd = 1'b0; dm_wen = 1'b0; end
    else ic_req = 1'b0;
    tick();
    check("ready_pulse1", {30'b0, ic_ready, dm_ready}, 32'h0);
    check("dead_idle", {31'b0, mem_req}, 32'h0);
  endtask

  task automatic drain(input int delay, input bit drop_mid);
    for (int g = 0; g < 4 && (ic_req || dm_rd || dm_wen); g++) serve(delay, drop_mid);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h0000_0013;
    do_reset();

    // IC fetch with immediate ack
    ic_req = 1'b1; ic_addr = 32'h0000_0100;
    drain(0, 1'b0);
    check("t1_icdata", ic_data, 32'h0000_0013);

    // store byte to lane 3
    dm_wen = 1'b1; dm_addr = 32'h0000_0203; dm_wd = 32'h0000_00AB; dm_f3 = 3'b000;
    drain(1, 1'b0);
    check("t2_memlane", mem[8'h80][31:24], 32'h0000_00AB);

    // simultaneous IC and DM reads
    ic_req = 1'b1; ic_addr = 32'h0000_0040;
    dm_rd = 1'b1; dm_addr = 32'h0000_0080; dm_f3 = 3'b010;
    drain(0, 1'b0);

    // three tie rounds (alternating under round robin)
    for (int r = 0; r < 3; r++) begin
      ic_req = 1'b1; ic_addr = $urandom;
      dm_rd = 1'b1; dm_addr = $urandom; dm_f3 = 3'b010;
      drain(0, 1'b0);
    end

    // slow memory
    ic_req = 1'b1; ic_addr = 32'h0000_0104;
    drain(5, 1'b0);

    // reset while in BUS_DM, late ack must be ignored
    dm_wen = 1'b1; dm_addr = 32'h0000_0010; dm_wd = 32'h1234_5678; dm_f3 = 3'b010;
    tick();
    check("t6_busreq", {31'b0, mem_req}, 32'h1);
    rst = 1'b0;
    tick();
    check("t6_req0", {31'b0, mem_req}, 32'h0);
    check("t6_addr0", mem_addr, 32'h0);
    check("t6_wdata0", mem_wdata, 32'h0);
    check("t6_be0", {28'b0, mem_be}, 32'h0);
    check("t6_we0", {31'b0, mem_we}, 32'h0);
    rst = 1'b1; dm_wen = 1'b0; last_dm = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_noready_a", {30'b0, ic_ready, dm_ready}, 32'h0);
    tick();
    check("t6_noready_b", {30'b0, ic_ready, dm_ready}, 32'h0);
    check("t6_idle", {31'b0, mem_req}, 32'h0);

    // randomized traffic
    for (int r = 0; r < 150; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      if (sel[0]) begin ic_req = 1'b1; ic_addr = $urandom; end
      if (sel[1]) begin
        dm_rd = 1'($urandom); dm_wen = 1'($urandom);
        if (!dm_rd && !dm_wen) dm_wen = 1'b1;
        dm_addr = $urandom; dm_wd = $urandom; dm_f3 = 3'($urandom);
      end
      drain($urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        check("gap_idle", {31'b0, mem_req}, 32'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
